// File: rtl/log_capture_mem_pkg.sv
// DSP sample log: shared widths and capture FSM encoding.
// Imported by the interface, the RAM and the capture top.
package log_capture_mem_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_ADDR_DEF = 15;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/log_capture_mem_if.sv
// Register-file / DSP side bundle of the sample log.
// The master drives run/data/read address; the slave is the log.
interface log_capture_mem_if
  import log_capture_mem_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) ();

  logic               i_run_log;
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic [NB_ADDR-1:0] i_read_addr;
  logic [NB_DATA-1:0] o_read_data;
  logic               o_mem_full;
  logic               o_busy;
  logic [NB_ADDR:0]   o_wr_count;

  modport master (
    output i_run_log,
    output i_data,
    output i_valid,
    output i_read_addr,
    input  o_read_data,
    input  o_mem_full,
    input  o_busy,
    input  o_wr_count
  );

  modport slave (
    input  i_run_log,
    input  i_data,
    input  i_valid,
    input  i_read_addr,
    output o_read_data,
    output o_mem_full,
    output o_busy,
    output o_wr_count
  );

endinterface

// File: rtl/log_ram.sv
// Simple dual-port block RAM for the sample log.
// Registered read-first read port; array contents are never reset.
module log_ram
  import log_capture_mem_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [NB_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0] wdata,
  input  logic [NB_ADDR-1:0] raddr,
  output logic [NB_DATA-1:0] rdata
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle write to raddr is seen next cycle, so reads return old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/log_capture_mem.sv
// Capture side of the DSP sample log: run-edge start, fill to full.
// Random-access registered read port for the register file.
module log_capture_mem
  import log_capture_mem_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic             clk,
  input  logic             i_rst,
  log_capture_mem_if.slave bus
);

  localparam logic [NB_ADDR-1:0] LAST = '1;

  state_t             state;
  state_t             state_n;
  logic               run_d;
  logic               run_edge;
  logic [NB_ADDR-1:0] ptr;
  logic [NB_ADDR-1:0] ptr_n;
  logic [NB_ADDR:0]   cnt;
  logic [NB_ADDR:0]   cnt_n;
  logic               we;

  assign run_edge = bus.i_run_log & ~run_d;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      run_d <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      run_d <= bus.i_run_log;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  // Run is a start pulse only: edges during capture are ignored.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    we      = 1'b0;
    unique case (state)
      S_IDLE, S_FULL: begin
        if (run_edge) begin
          state_n = S_CAPTURE;
          ptr_n   = '0;
          cnt_n   = '0;
        end
      end
      S_CAPTURE: begin
        if (bus.i_valid) begin
          we    = 1'b1;
          ptr_n = ptr + 1'b1;
          cnt_n = cnt + 1'b1;
          if (ptr == LAST) begin
            state_n = S_FULL;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.o_busy     = (state == S_CAPTURE);
  assign bus.o_mem_full = (state == S_FULL);
  assign bus.o_wr_count = cnt;

  log_ram #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_ram (
    .clk   (clk),
    .rst   (i_rst),
    .we    (we),
    .waddr (ptr),
    .wdata (bus.i_data),
    .raddr (bus.i_read_addr),
    .rdata (bus.o_read_data)
  );

endmodule

// File: tb/tb_log_capture_mem.sv
// Bench for log_capture_mem at depth 16 against a cycle model
// of the capture rules (start edge, fill count, read-first RAM).
module tb_log_capture_mem;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 16;

  logic clk   = 1'b0;
  logic i_rst = 1'b0;

  log_capture_mem_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

  log_capture_mem #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_run_prev;
  logic        m_cap;
  logic        m_full;
  int          m_cnt;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_rdata;
  bit          m_rd_known;

  task automatic model_reset();
    m_run_prev = 1'b0;
    m_cap      = 1'b0;
    m_full     = 1'b0;
    m_cnt      = 0;
    m_rdata    = '0;
    m_rd_known = 1'b1;
  endtask

  // Called at a negedge; applies inputs, advances the model, waits one cycle.
  task automatic step(input logic run, input logic valid,
                      input logic [31:0] data, input int raddr);
    bus.i_run_log   = run;
    bus.i_valid     = valid;
    bus.i_data      = data;
    bus.i_read_addr = NB_ADDR'(raddr);
    m_rdata    = m_mem[raddr];
    m_rd_known = m_known[raddr];
    if (m_cap) begin
      if (valid) begin
        m_mem[m_cnt]   = data;
        m_known[m_cnt] = 1'b1;
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_cap  = 1'b0;
          m_full = 1'b1;
        end
      end
    end else if (run && !m_run_prev) begin
      m_cap  = 1'b1;
      m_full = 1'b0;
      m_cnt  = 0;
    end
    m_run_prev = run;
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got %b want 0", bus.o_busy);
    end
    n_cmp++;
    if (bus.o_mem_full !== 1'b0) begin
      n_bad++; $display("FAIL reset_full got %b want 0", bus.o_mem_full);
    end
    n_cmp++;
    if (bus.o_wr_count !== 5'd0) begin
      n_bad++; $display("FAIL reset_count got %0d want 0", bus.o_wr_count);
    end
    n_cmp++;
    if (bus.o_read_data !== 32'd0) begin
      n_bad++; $display("FAIL reset_rdata got %h want 0", bus.o_read_data);
    end
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_full_capture();
    int a;
    step(1'b1, 1'b0, 32'd0, 0);
    n_cmp++;
    if (bus.o_busy !== 1'b1) begin
      n_bad++; $display("FAIL fc_busy_rise got %b want 1", bus.o_busy);
    end
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b0, 1'b1, 32'h100 + k, int'($urandom_range(0, DEPTH-1)));
      n_cmp++;
      if (bus.o_wr_count !== 5'(m_cnt) || bus.o_busy !== m_cap ||
          bus.o_mem_full !== m_full) begin
        n_bad++;
        $display("FAIL fc_status k=%0d got cnt=%0d busy=%b full=%b want %0d %b %b",
                 k, bus.o_wr_count, bus.o_busy, bus.o_mem_full, m_cnt, m_cap, m_full);
      end
    end
    n_cmp++;
    if (bus.o_mem_full !== 1'b1 || bus.o_wr_count !== 5'd16 || bus.o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fc_full got full=%b cnt=%0d busy=%b want 1 16 0",
               bus.o_mem_full, bus.o_wr_count, bus.o_busy);
    end
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b0, 1'b0, 32'd0, k);
      n_cmp++;
      if (bus.o_read_data !== 32'h100 + k) begin
        n_bad++;
        $display("FAIL fc_read a=%0d got %h want %h", k, bus.o_read_data, 32'h100 + k);
      end
    end
    for (int k = 0; k < 8; k++) begin
      a = int'($urandom_range(0, DEPTH-1));
      step(1'b0, 1'b0, $urandom, a);
      n_cmp++;
      if (bus.o_read_data !== m_rdata) begin
        n_bad++;
        $display("FAIL fc_rand_read a=%0d got %h want %h", a, bus.o_read_data, m_rdata);
      end
    end
  endtask

  task automatic test_gapped();
    logic [31:0] base;
    logic [31:0] ctr;
    int strobes;
    base    = $urandom;
    ctr     = base;
    strobes = 0;
    step(1'b1, 1'b0, 32'd0, 0);
    for (int cyc = 0; cyc < 80 && !m_full; cyc++) begin
      logic v;
      v = (cyc % 3 == 2);
      step(1'b0, v, v ? ctr : $urandom, int'($urandom_range(0, DEPTH-1)));
      if (v) begin
        ctr++;
        strobes++;
      end
      n_cmp++;
      if (bus.o_wr_count !== 5'(m_cnt) || bus.o_busy !== m_cap ||
          bus.o_mem_full !== m_full) begin
        n_bad++;
        $display("FAIL gap_status cyc=%0d got cnt=%0d busy=%b full=%b want %0d %b %b",
                 cyc, bus.o_wr_count, bus.o_busy, bus.o_mem_full, m_cnt, m_cap, m_full);
      end
    end
    n_cmp++;
    if (strobes != DEPTH || bus.o_mem_full !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_timeout got strobes=%0d full=%b want 16 1", strobes, bus.o_mem_full);
    end
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b0, 1'b0, 32'd0, k);
      n_cmp++;
      if (bus.o_read_data !== base + k) begin
        n_bad++;
        $display("FAIL gap_read a=%0d got %h want %h", k, bus.o_read_data, base + k);
      end
    end
  endtask

  task automatic test_ignore_run();
    logic        run;
    logic [31:0] newv;
    step(1'b1, 1'b0, 32'd0, 0);
    for (int cyc = 0; cyc < 80 && m_cap; cyc++) begin
      run = (m_cnt < 4) ? 1'b1 : (m_cnt < 5) ? 1'b0 : (m_cnt < 8) ? 1'b1 : 1'b0;
      step(run, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, DEPTH-1)));
      n_cmp++;
      if (bus.o_wr_count !== 5'(m_cnt) || bus.o_busy !== m_cap ||
          bus.o_mem_full !== m_full) begin
        n_bad++;
        $display("FAIL ign_status cyc=%0d got cnt=%0d busy=%b full=%b want %0d %b %b",
                 cyc, bus.o_wr_count, bus.o_busy, bus.o_mem_full, m_cnt, m_cap, m_full);
      end
    end
    n_cmp++;
    if (bus.o_mem_full !== 1'b1 || bus.o_wr_count !== 5'd16) begin
      n_bad++;
      $display("FAIL ign_full got full=%b cnt=%0d want 1 16", bus.o_mem_full, bus.o_wr_count);
    end
    step(1'b1, 1'b1, $urandom, 0);
    n_cmp++;
    if (bus.o_mem_full !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_wr_count !== 5'd0) begin
      n_bad++;
      $display("FAIL ign_restart got full=%b busy=%b cnt=%0d want 0 1 0",
               bus.o_mem_full, bus.o_busy, bus.o_wr_count);
    end
    newv = $urandom;
    step(1'b1, 1'b1, newv, 0);
    step(1'b0, 1'b0, 32'd0, 0);
    n_cmp++;
    if (bus.o_read_data !== newv) begin
      n_bad++;
      $display("FAIL ign_addr0 got %h want %h", bus.o_read_data, newv);
    end
    while (m_cap) step(1'b0, 1'b1, $urandom, 0);
  endtask

  task automatic test_collision();
    step(1'b1, 1'b0, 32'd0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b0, 1'b1, (k == 3) ? 32'h5555 : $urandom, 0);
    end
    step(1'b1, 1'b0, 32'd0, 0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, $urandom, 0);
    step(1'b0, 1'b1, 32'hAAAA, 3);
    n_cmp++;
    if (bus.o_read_data !== 32'h5555) begin
      n_bad++;
      $display("FAIL coll_old got %h want 00005555", bus.o_read_data);
    end
    step(1'b0, 1'b0, 32'd0, 3);
    n_cmp++;
    if (bus.o_read_data !== 32'hAAAA) begin
      n_bad++;
      $display("FAIL coll_new got %h want 0000aaaa", bus.o_read_data);
    end
    while (m_cap) step(1'b0, 1'b1, $urandom, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] saved [7];
    step(1'b1, 1'b0, 32'd0, 0);
    for (int k = 0; k < 7; k++) begin
      saved[k] = $urandom;
      step(1'b0, 1'b1, saved[k], 0);
    end
    bus.i_valid = 1'b1;
    bus.i_data  = $urandom;
    #2;
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_mem_full !== 1'b0 || bus.o_wr_count !== 5'd0) begin
      n_bad++;
      $display("FAIL mid_reset got busy=%b full=%b cnt=%0d want 0 0 0",
               bus.o_busy, bus.o_mem_full, bus.o_wr_count);
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    model_reset();
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0, 32'd0, k);
      n_cmp++;
      if (bus.o_read_data !== saved[k] || bus.o_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_keep a=%0d got %h busy=%b want %h 0",
                 k, bus.o_read_data, bus.o_busy, saved[k]);
      end
    end
  endtask

  task automatic test_run_held();
    bus.i_run_log = 1'b1;
    i_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 32'd0, 0);
    n_cmp++;
    if (bus.o_busy !== 1'b1) begin
      n_bad++; $display("FAIL held_start got busy=%b want 1", bus.o_busy);
    end
    for (int k = 0; k < DEPTH + 6; k++) begin
      step(1'b1, 1'b1, $urandom, int'($urandom_range(0, DEPTH-1)));
      n_cmp++;
      if (bus.o_wr_count !== 5'(m_cnt) || bus.o_busy !== m_cap ||
          bus.o_mem_full !== m_full) begin
        n_bad++;
        $display("FAIL held_status k=%0d got cnt=%0d busy=%b full=%b want %0d %b %b",
                 k, bus.o_wr_count, bus.o_busy, bus.o_mem_full, m_cnt, m_cap, m_full);
      end
    end
    n_cmp++;
    if (bus.o_mem_full !== 1'b1 || bus.o_wr_count !== 5'd16) begin
      n_bad++;
      $display("FAIL held_retrig got full=%b cnt=%0d want 1 16",
               bus.o_mem_full, bus.o_wr_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_run_log   = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_data      = '0;
    bus.i_read_addr = '0;
    for (int k = 0; k < DEPTH; k++) m_known[k] = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_full_capture();
    test_gapped();
    test_ignore_run();
    test_collision();
    test_reset_mid();
    test_run_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
